regfile_wb_arbiter: RTL

Shares the single register-file write port (we3/wa3/wd3) between two writeback requesters: A (ALU/execute result) and B (memory load result). Each requester pushes into its own small FIFO through a valid/ready handshake. A round-robin arbiter drains the FIFO heads one per cycle into a registered write port that drives the register file directly. The block sits between the writeback stage and the register file.

---
 rtl/regfile_wb_arbiter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter: two requester FIFOs share one registered register-file write port.
// Optional macro WB_SCOREBOARD_EN adds pend_mask, a per-register "write still in flight" view.
module regfile_wb_arbiter #(
   parameter int DATA_W     = 64,
   parameter int ADDR_W     = 5,
   parameter int FIFO_DEPTH = 2,
   parameter int ZERO_REG   = 31
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              a_valid,
   output logic              a_ready,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_data,
   input  logic              b_valid,
   output logic              b_ready,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_data,
   output logic              we3,
   output logic [ADDR_W-1:0] wa3,
   output logic [DATA_W-1:0] wd3,
`ifdef WB_SCOREBOARD_EN
   output logic [2**ADDR_W-1:0] pend_mask,
`endif
   output logic              wb_idle
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;

   // Index 0 is requester A, index 1 is requester B.
   logic [ADDR_W-1:0] in_addr [2];
   logic [DATA_W-1:0] in_data [2];
   logic [1:0]        in_valid;
   logic [1:0]        ready;
   logic [1:0]        store;
   logic [1:0]        empty;
   logic [1:0]        grant;

   logic [ADDR_W-1:0] mem_addr [2][FIFO_DEPTH];
   logic [DATA_W-1:0] mem_data [2][FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr [2];
   logic [PTR_W-1:0]  rd_ptr [2];
   logic [CNT_W-1:0]  cnt [2];

   logic              rr_favor_b;
   logic              sel;
   logic [ADDR_W-1:0] head_addr;
   logic [DATA_W-1:0] head_data;

   assign in_addr[0]  = a_addr;
   assign in_addr[1]  = b_addr;
   assign in_data[0]  = a_data;
   assign in_data[1]  = b_data;
   assign in_valid    = {b_valid, a_valid};
   assign a_ready     = ready[0];
   assign b_ready     = ready[1];

   always_comb begin
      for (int r = 0; r < 2; r++) begin
         ready[r] = (cnt[r] != CNT_W'(FIFO_DEPTH));
         empty[r] = (cnt[r] == '0);
         // XZR writes complete the handshake but never enter the FIFO.
         store[r] = in_valid[r] && ready[r] && (in_addr[r] != ADDR_W'(ZERO_REG));
      end
   end

   always_comb begin
      grant = 2'b00;
      if (!empty[0] && !empty[1])
         grant = rr_favor_b ? 2'b10 : 2'b01;
      else if (!empty[0])
         grant = 2'b01;
      else if (!empty[1])
         grant = 2'b10;
   end

   assign sel       = grant[1];
   assign head_addr = mem_addr[sel][rd_ptr[sel]];
   assign head_data = mem_data[sel][rd_ptr[sel]];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int r = 0; r < 2; r++) begin
            wr_ptr[r] <= '0;
            rd_ptr[r] <= '0;
            cnt[r]    <= '0;
         end
         rr_favor_b <= 1'b0;
         we3        <= 1'b0;
         wa3        <= '0;
         wd3        <= '0;
      end else begin
         for (int r = 0; r < 2; r++) begin
            if (store[r])
               wr_ptr[r] <= wr_ptr[r] + PTR_W'(1);
            if (grant[r])
               rd_ptr[r] <= rd_ptr[r] + PTR_W'(1);
            cnt[r] <= cnt[r] + CNT_W'(store[r]) - CNT_W'(grant[r]);
         end
         if (grant[0])
            rr_favor_b <= 1'b1;
         else if (grant[1])
            rr_favor_b <= 1'b0;
         we3 <= |grant;
         if (|grant) begin
            wa3 <= head_addr;
            wd3 <= head_data;
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int r = 0; r < 2; r++) begin
         if (store[r]) begin
            mem_addr[r][wr_ptr[r]] <= in_addr[r];
            mem_data[r][wr_ptr[r]] <= in_data[r];
         end
      end
   end

   assign wb_idle = empty[0] && empty[1] && !we3;

`ifdef WB_SCOREBOARD_EN
   localparam int NREG = 2**ADDR_W;
   // Worst case in flight per register: both FIFOs full plus one in the output register.
   localparam int SC_W = $clog2(2*FIFO_DEPTH + 2);

   logic [SC_W-1:0] pend_cnt [NREG];
   logic [SC_W-1:0] pend_nxt [NREG];

   always_comb begin
      for (int i = 0; i < NREG; i++) begin
         pend_nxt[i] = pend_cnt[i];
         if (store[0] && (a_addr == ADDR_W'(i)))
            pend_nxt[i] = pend_nxt[i] + SC_W'(1);
         if (store[1] && (b_addr == ADDR_W'(i)))
            pend_nxt[i] = pend_nxt[i] + SC_W'(1);
         if (we3 && (wa3 == ADDR_W'(i)))
            pend_nxt[i] = pend_nxt[i] - SC_W'(1);
         pend_mask[i] = (pend_cnt[i] != '0);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NREG; i++)
            pend_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < NREG; i++)
            pend_cnt[i] <= pend_nxt[i];
      end
   end
`endif

endmodule
